// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI bring-up controller.
// Frame layout is {rw, addr[6:0], data[7:0]}, MSB first.
package spi_pkg;

  localparam int SPI_FRAME_W = 16;
  localparam int SPI_ADDR_W  = 7;
  localparam int SPI_DATA_W  = 8;

  localparam logic [SPI_ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
  localparam logic [SPI_ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
  localparam logic [SPI_ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
  localparam logic [SPI_ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
  localparam logic [SPI_ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_GAP
  } spi_ctrl_state_t;

  function automatic int max4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/spi_if.sv
// Command port between the bring-up sequencer and the SPI controller.
// valid/ready handshake; fields are latched on the accepting edge.
interface spi_cmd_if;
  import spi_pkg::*;

  logic                  valid;
  logic                  ready;
  logic                  write;
  logic [SPI_ADDR_W-1:0] addr;
  logic [SPI_DATA_W-1:0] data;

  modport master (
    output valid,
    output write,
    output addr,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  write,
    input  addr,
    input  data,
    output ready
  );

endinterface

// File: rtl/spi_phase_timer.sv
// Loadable down-counter timing each SPI phase.
// expired is high while the count sits at zero.
module spi_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write-only initiator: shifts one 16-bit frame per command.
// FSM, shifter and bit counter here; phase lengths from spi_phase_timer.
module spi_controller
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int CS_IDLE     = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  spi_cmd_if.slave cmd,
  output logic     busy,
  output logic     done,
  output logic     sclk,
  output logic     ncs,
  output logic     copi
);

  localparam int TW =
    $clog2(max4(HALF_PERIOD, CS_SETUP, CS_HOLD, CS_IDLE)) + 1;

  localparam logic [TW-1:0] T_SETUP = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] T_HALF  = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] T_HOLD  = TW'(CS_HOLD - 1);
  localparam logic [TW-1:0] T_IDLE  = TW'(CS_IDLE - 1);

  if (HALF_PERIOD < 3 || CS_SETUP < 1 ||
      CS_HOLD < 2 || CS_IDLE < 3) begin : g_bad_param
    $error("spi_controller: illegal timing parameter");
  end

  spi_ctrl_state_t        state;
  logic [SPI_FRAME_W-1:0] sr;
  logic [4:0]             bit_cnt;
  logic                   ready_q;
  logic                   accept;
  logic                   expired;
  logic                   tmr_load;
  logic [TW-1:0]          tmr_val;

  assign accept    = cmd.valid && ready_q;
  assign cmd.ready = ready_q;

  spi_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (expired)
  );

  // Timer reloads on every phase change, with the next phase's length.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state)
      ST_IDLE: begin
        tmr_load = accept;
        tmr_val  = T_SETUP;
      end
      ST_SETUP, ST_HIGH: begin
        tmr_load = expired;
        tmr_val  = T_HALF;
      end
      ST_LOW: begin
        tmr_load = expired;
        tmr_val  = (bit_cnt == 5'd16) ? T_HOLD : T_HALF;
      end
      ST_HOLD: begin
        tmr_load = expired;
        tmr_val  = T_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      ncs     <= 1'b1;
      copi    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: if (accept) begin
          sr      <= {cmd.write, cmd.addr, cmd.data};
          copi    <= cmd.write;
          ncs     <= 1'b0;
          bit_cnt <= '0;
          busy    <= 1'b1;
          ready_q <= 1'b0;
          state   <= ST_SETUP;
        end
        ST_SETUP: if (expired) begin
          sclk  <= 1'b1;
          state <= ST_HIGH;
        end
        // Fall edge: present the next bit; the last bit is held.
        ST_HIGH: if (expired) begin
          sclk    <= 1'b0;
          bit_cnt <= bit_cnt + 5'd1;
          state   <= ST_LOW;
          if (bit_cnt != 5'd15) begin
            sr   <= {sr[SPI_FRAME_W-2:0], sr[SPI_FRAME_W-1]};
            copi <= sr[SPI_FRAME_W-2];
          end
        end
        ST_LOW: if (expired) begin
          if (bit_cnt == 5'd16) begin
            state <= ST_HOLD;
          end else begin
            sclk  <= 1'b1;
            state <= ST_HIGH;
          end
        end
        ST_HOLD: if (expired) begin
          ncs   <= 1'b1;
          copi  <= 1'b0;
          done  <= 1'b1;
          state <= ST_GAP;
        end
        ST_GAP: if (expired) begin
          busy    <= 1'b0;
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: SPI receiver model and protocol checker
// on two instances (default timing and HALF_PERIOD=3).
module tb_spi_controller;
  import spi_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] busy, done, sclk, ncs, copi;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;

  spi_cmd_if cif0 ();
  spi_cmd_if cif1 ();

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_controller dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (cif0),
    .busy  (busy[0]),
    .done  (done[0]),
    .sclk  (sclk[0]),
    .ncs   (ncs[0]),
    .copi  (copi[0])
  );

  spi_controller #(.HALF_PERIOD(3)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (cif1),
    .busy  (busy[1]),
    .done  (done[1]),
    .sclk  (sclk[1]),
    .ncs   (ncs[1]),
    .copi  (copi[1])
  );

  // Receiver model + protocol checker, sampled mid-cycle.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic       p_sclk = 1'b0, p_ncs = 1'b1;
    logic       p_copi = 1'b0, pp_copi = 1'b0;
    logic [15:0] sh = '0, last_frame = '0, prev_frame = '0;
    logic [7:0] regs [5] = '{default: 8'h00};
    int bits = 0, rises = 0, lowlen = 0, last_low = 0;
    int hilen = 0, last_high = 0, frames = 0, discards = 0;
    int last_bits = 0, dones = 0, perr = 0, cerr = 0;

    always @(negedge clk) begin
      if (p_ncs && !ncs[g]) begin
        bits = 0;
        sh = '0;
        lowlen = 0;
        last_high = hilen;
      end
      if (!p_ncs && ncs[g]) begin
        last_low = lowlen;
        hilen = 0;
        if (bits == 16) begin
          prev_frame = last_frame;
          last_frame = sh;
          frames++;
          if (!done[g]) perr++;
          if (sh[15] && sh[14:8] < 7'd5) regs[int'(sh[14:8])] = sh[7:0];
        end else begin
          discards++;
          last_bits = bits;
        end
      end else if (done[g]) begin
        perr++;
      end
      if (ncs[g]) hilen++;
      else lowlen++;
      if (!p_sclk && sclk[g]) begin
        rises++;
        bits++;
        sh = {sh[14:0], copi[g]};
        if (copi[g] !== p_copi || p_copi !== pp_copi) cerr++;
      end
      if (sclk[g] && ncs[g]) perr++;
      if (done[g]) dones++;
      pp_copi = p_copi;
      p_copi  = copi[g];
      p_sclk  = sclk[g];
      p_ncs   = ncs[g];
    end
  end

  typedef struct {
    logic        w;
    logic [6:0]  a;
    logic [7:0]  d;
    logic [15:0] f;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int i);
    return (i == 0) ? cif0.ready : cif1.ready;
  endfunction

  function automatic int nframes(input int i);
    return (i == 0) ? g_mon[0].frames : g_mon[1].frames;
  endfunction

  task automatic send(input int i, input logic w, input logic [6:0] a,
                      input logic [7:0] d, output int t_acc);
    int n;
    n = 0;
    if (i == 0) begin
      cif0.valid = 1'b1; cif0.write = w; cif0.addr = a; cif0.data = d;
    end else begin
      cif1.valid = 1'b1; cif1.write = w; cif1.addr = a; cif1.data = d;
    end
    while (rdy(i) !== 1'b1 && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("accept_wait", 32'(n < 1000), 32'd1);
    @(posedge clk); #1;
    t_acc = cyc;
    if (i == 0) begin
      cif0.valid = 1'b0; cif0.write = ~w; cif0.addr = ~a; cif0.data = ~d;
    end else begin
      cif1.valid = 1'b0; cif1.write = ~w; cif1.addr = ~a; cif1.data = ~d;
    end
  endtask

  task automatic wait_frames(input int i, input int target);
    int n;
    n = 0;
    while (nframes(i) < target && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("frame_wait", 32'(n < 1000), 32'd1);
  endtask

  initial begin
    int t0, t1, f0, r0, dc0, ds0, c0, b, n;
    logic [7:0] exp_regs [5];

    tbl[0] = '{1'b1, REG_PWM_DUTY,    8'h80, 16'h8480};
    tbl[1] = '{1'b1, REG_EN_OUT_7_0,  8'hF0, 16'h80F0};
    tbl[2] = '{1'b1, REG_EN_OUT_15_8, 8'h0F, 16'h810F};
    tbl[3] = '{1'b0, REG_EN_PWM_7_0,  8'hFF, 16'h02FF};
    tbl[4] = '{1'b1, REG_EN_PWM_15_8, 8'h5A, 16'h835A};
    exp_regs = '{8'hF0, 8'h0F, 8'h00, 8'h5A, 8'h80};

    cif0.valid = 1'b0; cif0.write = 1'b0; cif0.addr = '0; cif0.data = '0;
    cif1.valid = 1'b0; cif1.write = 1'b0; cif1.addr = '0; cif1.data = '0;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs",
        32'({ncs, sclk, copi, cif0.ready, cif1.ready, busy, done}),
        32'(12'b11_00_00_1_1_00_00));
    rst_n = 1'b1;

    b = 0;
    repeat (100) begin
      @(negedge clk); #1;
      if ({ncs, sclk, copi, cif0.ready, cif1.ready, busy, done}
          !== 12'b11_00_00_1_1_00_00) b++;
    end
    chk("idle_100cyc", 32'(b), 32'd0);

    foreach (tbl[i]) begin
      f0  = g_mon[0].frames;
      r0  = g_mon[0].rises;
      dc0 = g_mon[0].dones;
      send(0, tbl[i].w, tbl[i].a, tbl[i].d, t0);
      wait_frames(0, f0 + 1);
      chk($sformatf("frame_%0d", i), 32'(g_mon[0].last_frame), 32'(tbl[i].f));
      chk("ncs_low_len", 32'(g_mon[0].last_low), 32'd132);
      chk("sclk_rises", 32'(g_mon[0].rises - r0), 32'd16);
      chk("done_pulses", 32'(g_mon[0].dones - dc0), 32'd1);
    end

    f0 = g_mon[0].frames;
    send(0, 1'b1, REG_EN_OUT_7_0, 8'hF0, t0);
    chk("busy_after_accept", 32'({busy[0], cif0.ready}), 32'(2'b10));
    send(0, 1'b1, REG_EN_OUT_15_8, 8'h0F, t1);
    chk("b2b_accept_gap", 32'(t1 - t0), 32'd137);
    wait_frames(0, f0 + 2);
    chk("b2b_frame_a", 32'(g_mon[0].prev_frame), 32'h80F0);
    chk("b2b_frame_b", 32'(g_mon[0].last_frame), 32'h810F);
    chk("b2b_ncs_high", 32'(g_mon[0].last_high), 32'd5);

    f0 = g_mon[1].frames;
    c0 = g_mon[1].cerr;
    send(1, 1'b1, 7'h55, 8'hAA, t0);
    send(1, 1'b0, 7'h2A, 8'h55, t1);
    wait_frames(1, f0 + 2);
    chk("hp3_frame_a", 32'(g_mon[1].prev_frame), 32'hD5AA);
    chk("hp3_frame_b", 32'(g_mon[1].last_frame), 32'h2A55);
    chk("hp3_copi_stable", 32'(g_mon[1].cerr - c0), 32'd0);
    chk("hp3_ncs_low_len", 32'(g_mon[1].last_low), 32'd100);

    f0  = g_mon[0].frames;
    dc0 = g_mon[0].dones;
    ds0 = g_mon[0].discards;
    send(0, 1'b1, REG_EN_OUT_7_0, 8'h3C, t0);
    n = 0;
    while (!(g_mon[0].bits == 7 && ncs[0] == 1'b0) && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("wait_7_bits", 32'(n < 1000), 32'd1);
    chk("sclk_high_before_abort", 32'(sclk[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs",
        32'({ncs[0], sclk[0], copi[0], busy[0], done[0], cif0.ready}),
        32'(6'b100001));
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("abort_discards", 32'(g_mon[0].discards - ds0), 32'd1);
    chk("abort_bits", 32'(g_mon[0].last_bits), 32'd7);
    chk("abort_no_done", 32'(g_mon[0].dones - dc0), 32'd0);
    chk("abort_no_frame", 32'(g_mon[0].frames - f0), 32'd0);

    chk("protocol_dut0", 32'(g_mon[0].perr), 32'd0);
    chk("protocol_dut1", 32'(g_mon[1].perr), 32'd0);
    chk("copi_stable_dut0", 32'(g_mon[0].cerr), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("reg_%0d", i), 32'(g_mon[0].regs[i]), 32'(exp_regs[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
